// File: rtl/age_issue_pkg.sv
// Shared defaults and age type for the age-ordered issue selector.
package age_issue_pkg;

  localparam int SIZE_DEF    = 8;
  localparam int ISSUE_W_DEF = 2;
  localparam int AGE_W_DEF   = 4;

  typedef logic [AGE_W_DEF-1:0] age_t;

endpackage

// File: rtl/age_issue_select_oldest_pick.sv
// Combinational pick of the oldest entry in a mask.
// Strict compare keeps the lowest index on equal ages.
module oldest_pick
  import age_issue_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int AGE_W = AGE_W_DEF,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]       mask_i,
  input  logic [SIZE*AGE_W-1:0] ages_i,
  output logic [SIZE-1:0]       onehot_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  valid_o
);

  logic [AGE_W-1:0] best;

  always_comb begin
    best     = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    onehot_o = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (mask_i[i] &&
          (!valid_o ||
           ages_i[i*AGE_W +: AGE_W] > best)) begin
        valid_o = 1'b1;
        best    = ages_i[i*AGE_W +: AGE_W];
        idx_o   = IDX_W'(i);
      end
    end
    if (valid_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/age_issue_select.sv
// Age-ordered multi-grant issue selector with per-entry
// occupancy and saturating age counters.
module age_issue_select
  import age_issue_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int ISSUE_W = ISSUE_W_DEF,
  parameter int AGE_W   = AGE_W_DEF,
  localparam int IDX_W  = $clog2(SIZE)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [SIZE-1:0]          alloc_i,
  input  logic [SIZE-1:0]          ready_i,
  input  logic                     issue_en_i,
  input  logic                     flush_i,
  output logic [SIZE-1:0]          grant_o,
  output logic [ISSUE_W-1:0]       grant_valid_o,
  output logic [ISSUE_W*IDX_W-1:0] grant_idx_o,
  output logic [SIZE-1:0]          occ_o,
  output logic                     alloc_err_o
);

  logic [SIZE-1:0]       occ_q, occ_d;
  logic [SIZE*AGE_W-1:0] age_q, age_d;
  logic                  err_q, err_d;
  logic [SIZE-1:0]       elig;
  logic [SIZE-1:0]       mask [ISSUE_W];
  logic [SIZE-1:0]       oh   [ISSUE_W];

  assign elig = occ_q & ready_i &
                {SIZE{~flush_i & issue_en_i}};

  // Each slot sees the mask minus all earlier slots' picks.
  for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
    if (k == 0) begin : g_first
      assign mask[k] = elig;
    end else begin : g_next
      assign mask[k] = mask[k-1] & ~oh[k-1];
    end
    oldest_pick #(
      .SIZE  (SIZE),
      .AGE_W (AGE_W),
      .IDX_W (IDX_W)
    ) u_pick (
      .mask_i   (mask[k]),
      .ages_i   (age_q),
      .onehot_o (oh[k]),
      .idx_o    (grant_idx_o[k*IDX_W +: IDX_W]),
      .valid_o  (grant_valid_o[k])
    );
  end

  always_comb begin
    grant_o = '0;
    for (int k = 0; k < ISSUE_W; k++)
      grant_o = grant_o | oh[k];
  end

  always_comb begin
    occ_d = occ_q;
    age_d = age_q;
    err_d = err_q | (~flush_i & (|(alloc_i & occ_q)));
    for (int i = 0; i < SIZE; i++) begin
      if (flush_i || grant_o[i]) begin
        occ_d[i]                 = 1'b0;
        age_d[i*AGE_W +: AGE_W]  = '0;
      end else if (occ_q[i]) begin
        if (age_q[i*AGE_W +: AGE_W] != '1)
          age_d[i*AGE_W +: AGE_W] =
            age_q[i*AGE_W +: AGE_W] + 1'b1;
      end else if (alloc_i[i]) begin
        occ_d[i]                 = 1'b1;
        age_d[i*AGE_W +: AGE_W]  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      occ_q <= '0;
      age_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      age_q <= age_d;
      err_q <= err_d;
    end
  end

  assign occ_o       = occ_q;
  assign alloc_err_o = err_q;

endmodule
